rename_alloc_ctrl: RTL
======================

# rename_alloc_ctrl

Sequencing controller between the rename stage, the commit stage and the physical-register free list. It grants rename allocation bundles only when the free list can cover them and turns the free list's registered outputs into a one-cycle allocation pulse. It owns the free list's retire port, sharing it between commit retirements and reclaim of allocations squashed by a pipeline flush.

## Interface
- `LEN`, 48, number of physical registers; must match the free list.
- `LBITS`, `$clog2(LEN)`, physical register index width.
- `STALL_CNT_W`, 16, width of the stall statistics counter.

- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `i_ren_valid` in 1: rename bundle requesting allocation.
- `i_ren_count` in 3: destination registers needed, 0..4.
- `o_ren_ready` out 1: bundle accepted this cycle.
- `o_alloc_valid` out 1: allocation pulse to rename; no backpressure.
- `o_alloc_count` out 3: number of valid `o_alloc_p*`.
- `o_alloc_p0`..`o_alloc_p3` out LBITS each: allocated registers, lowest index first.
- `i_cmt_valid` in 1: commit retiring registers.
- `i_cmt_count` in 3: registers retired, 1..4.
- `i_cmt_p0`..`i_cmt_p3` in LBITS each: retired registers.
- `o_cmt_ready` out 1: commit retirement accepted.
- `i_flush` in 1: single-cycle pipeline flush.
- `o_fl_req_count` out 3: request count to the free list.
- `i_fl_req0`..`i_fl_req3` in LBITS each: free list allocated registers (registered outputs).
- `i_fl_req_count` in 3: free list's mirrored request count.
- `i_fl_avail_count` in LBITS: free list available count.
- `o_fl_ret_count` out 3: retire count to the free list.
- `o_fl_ret_p0`..`o_fl_ret_p3` out LBITS each: retire registers to the free list.
- `o_stall_cycles` out STALL_CNT_W: rename stall cycle count.

## Operation
- States: RUN and RECLAIM. Reset state is RUN.
- **Accept (combinational).** `o_ren_ready` = state==RUN && !i_flush && i_ren_count<=4 && i_ren_count<=i_fl_avail_count.
  - `o_fl_req_count` = (i_ren_valid && o_ren_ready) ? i_ren_count : 0.
  - A count of 0 is accepted and produces no alloc pulse.
  - i_ren_count>4 is never accepted.
- **Availability check.** Uses `i_fl_avail_count` as registered, which is conservative. Same-cycle retirements are not credited.
- **Output stage (registered).** Each cycle, when i_fl_req_count!=0 and !i_flush:
  - `o_alloc_valid`<=1, `o_alloc_count`<=i_fl_req_count, `o_alloc_p*`<=i_fl_req*.
  - Otherwise `o_alloc_valid`<=0, `o_alloc_count`<=0. `o_alloc_p*` hold their values.
- **Squash.** When i_flush && i_fl_req_count!=0:
  - The free-list stage contents are captured into the reclaim buffer (count plus 4 regs).
  - State goes to RECLAIM.
  - An alloc pulse already on `o_alloc_*` in the flush cycle is delivered, not squashed.
- **Retire port in RUN.** `o_cmt_ready`=1.
  - `o_fl_ret_count` = i_cmt_valid ? i_cmt_count : 0.
  - `o_fl_ret_p*` = i_cmt_p*, passed combinationally.
- **Retire port in RECLAIM.** `o_cmt_ready`=0 and `o_ren_ready`=0.
  - `o_fl_ret_count`/`o_fl_ret_p*` = reclaim buffer.
  - Next state is RUN; the buffer count clears to 0.
- **Flush during RECLAIM.** Ignored. The free-list stage is empty because nothing was accepted in the flush cycle.
- **Flush with nothing in flight.** No state change; `o_ren_ready`=0 for that cycle only.
- **Unused ports.** Unused `o_fl_ret_p*` lanes (index >= count) are don't-care, but are driven deterministically from the selected source.

## Timing
- **Alloc latency.** Accept at cycle T; the free list registers at T+1; `o_alloc_valid` is high at T+2 for exactly one cycle.
- **Throughput.** Back-to-back accepts give back-to-back alloc pulses.
- **Flush at F.** Squashes the bundle accepted at F-1. RECLAIM occupies F+1. Commit and rename resume at F+2.
- **Reset values.** State RUN, `o_alloc_valid`=0, `o_alloc_count`=0, `o_alloc_p*`=0, reclaim buffer cleared, `o_stall_cycles`=0.
- **Combinational outputs during reset.** Evaluate as RUN.
- **Reset mid-operation.** Discards in-flight and reclaim state immediately (asynchronous). Nothing is retired.

## Configuration
- `ALLOC_STALL_CNT_EN` defined:
  - `o_stall_cycles` increments each cycle i_ren_valid && !o_ren_ready, saturating at all-ones.
  - It does not increment on flush cycles.
- `ALLOC_STALL_CNT_EN` undefined: the port remains and is tied to 0; no counter flops exist.

## Test plan
- **Basic allocation.** Reset (avail 48), then i_ren_valid, count 4 at T -> `o_ren_ready`=1 and `o_fl_req_count`=4 at T; at T+2 `o_alloc_valid`=1, count 4, p0..p3=0,1,2,3.
- **Insufficient availability.** i_fl_avail_count=2, request count 3 -> `o_ren_ready`=0 and `o_fl_req_count`=0 while held. Once avail>=3 -> accepted that cycle.
- **Squash and reclaim.** Accept count 2 (regs 4,5) at T, i_flush at T+1:
  - No alloc pulse at T+2.
  - At T+2: `o_fl_ret_count`=2, p0=4, p1=5, `o_cmt_ready`=0, `o_ren_ready`=0.
  - RUN at T+3.
- **Commit passthrough.** In RUN, i_cmt_valid, count 3, regs 10,11,12 -> `o_fl_ret_count`=3 and p0..p2=10,11,12 the same cycle; `o_cmt_ready`=1.
- **Reset mid-operation.** Assert reset during RECLAIM -> `o_fl_ret_count` reflects RUN/commit immediately, `o_alloc_valid`=0, nothing reclaimed after release.
- **Stall counter (`ALLOC_STALL_CNT_EN`).** 5 stalled cycles -> `o_stall_cycles`=5. Preloaded near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/rename_alloc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rename_alloc_ctrl: grants rename allocation against the free list and      |
// | arbitrates the free-list retire port between commit and flush reclaim.     |
// | Optional feature macro: ALLOC_STALL_CNT_EN (rename stall cycle counter).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rename_alloc_ctrl #(
  parameter int LEN         = 48,
  parameter int LBITS       = $clog2(LEN),
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ren_valid,
  input  logic [2:0]             i_ren_count,
  output logic                   o_ren_ready,
  output logic                   o_alloc_valid,
  output logic [2:0]             o_alloc_count,
  output logic [LBITS-1:0]       o_alloc_p0,
  output logic [LBITS-1:0]       o_alloc_p1,
  output logic [LBITS-1:0]       o_alloc_p2,
  output logic [LBITS-1:0]       o_alloc_p3,
  input  logic                   i_cmt_valid,
  input  logic [2:0]             i_cmt_count,
  input  logic [LBITS-1:0]       i_cmt_p0,
  input  logic [LBITS-1:0]       i_cmt_p1,
  input  logic [LBITS-1:0]       i_cmt_p2,
  input  logic [LBITS-1:0]       i_cmt_p3,
  output logic                   o_cmt_ready,
  input  logic                   i_flush,
  output logic [2:0]             o_fl_req_count,
  input  logic [LBITS-1:0]       i_fl_req0,
  input  logic [LBITS-1:0]       i_fl_req1,
  input  logic [LBITS-1:0]       i_fl_req2,
  input  logic [LBITS-1:0]       i_fl_req3,
  input  logic [2:0]             i_fl_req_count,
  input  logic [LBITS-1:0]       i_fl_avail_count,
  output logic [2:0]             o_fl_ret_count,
  output logic [LBITS-1:0]       o_fl_ret_p0,
  output logic [LBITS-1:0]       o_fl_ret_p1,
  output logic [LBITS-1:0]       o_fl_ret_p2,
  output logic [LBITS-1:0]       o_fl_ret_p3,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  localparam int CW = (LBITS > 3) ? LBITS : 3;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECLAIM = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_alloc_valid;
  logic [2:0]       r_alloc_count;
  logic [LBITS-1:0] r_alloc_p0;
  logic [LBITS-1:0] r_alloc_p1;
  logic [LBITS-1:0] r_alloc_p2;
  logic [LBITS-1:0] r_alloc_p3;
  logic [2:0]       r_rcl_count;
  logic [LBITS-1:0] r_rcl_p0;
  logic [LBITS-1:0] r_rcl_p1;
  logic [LBITS-1:0] r_rcl_p2;
  logic [LBITS-1:0] r_rcl_p3;

  logic          w_run;
  logic          w_cnt_ok;
  logic          w_avail_ok;
  logic          w_fl_busy;
  logic [CW-1:0] w_ren_cnt_ext;
  logic [CW-1:0] w_avail_ext;

  assign w_run         = (r_state == ST_RUN);
  assign w_fl_busy     = (i_fl_req_count != 3'd0);
  assign w_ren_cnt_ext = CW'(i_ren_count);
  assign w_avail_ext   = CW'(i_fl_avail_count);
  assign w_cnt_ok      = (i_ren_count <= 3'd4);
  // Registered availability only; same-cycle retirements are not credited.
  assign w_avail_ok    = (w_ren_cnt_ext <= w_avail_ext);

  assign o_ren_ready    = w_run && !i_flush && w_cnt_ok && w_avail_ok;
  assign o_fl_req_count = (i_ren_valid && o_ren_ready) ? i_ren_count : 3'd0;
  assign o_cmt_ready    = w_run;

  always_comb begin
    o_fl_ret_count = 3'd0;
    o_fl_ret_p0    = i_cmt_p0;
    o_fl_ret_p1    = i_cmt_p1;
    o_fl_ret_p2    = i_cmt_p2;
    o_fl_ret_p3    = i_cmt_p3;
    if (w_run) begin
      o_fl_ret_count = i_cmt_valid ? i_cmt_count : 3'd0;
    end else begin
      o_fl_ret_count = r_rcl_count;
      o_fl_ret_p0    = r_rcl_p0;
      o_fl_ret_p1    = r_rcl_p1;
      o_fl_ret_p2    = r_rcl_p2;
      o_fl_ret_p3    = r_rcl_p3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_alloc_valid <= 1'b0;
      r_alloc_count <= 3'd0;
      r_alloc_p0    <= '0;
      r_alloc_p1    <= '0;
      r_alloc_p2    <= '0;
      r_alloc_p3    <= '0;
      r_rcl_count   <= 3'd0;
      r_rcl_p0      <= '0;
      r_rcl_p1      <= '0;
      r_rcl_p2      <= '0;
      r_rcl_p3      <= '0;
    end else begin
      if (w_fl_busy && !i_flush) begin
        r_alloc_valid <= 1'b1;
        r_alloc_count <= i_fl_req_count;
        r_alloc_p0    <= i_fl_req0;
        r_alloc_p1    <= i_fl_req1;
        r_alloc_p2    <= i_fl_req2;
        r_alloc_p3    <= i_fl_req3;
      end else begin
        r_alloc_valid <= 1'b0;
        r_alloc_count <= 3'd0;
      end

      case (r_state)
        ST_RUN: begin
          // A flush squashes the bundle sitting in the free-list stage.
          if (i_flush && w_fl_busy) begin
            r_rcl_count <= i_fl_req_count;
            r_rcl_p0    <= i_fl_req0;
            r_rcl_p1    <= i_fl_req1;
            r_rcl_p2    <= i_fl_req2;
            r_rcl_p3    <= i_fl_req3;
            r_state     <= ST_RECLAIM;
          end
        end
        ST_RECLAIM: begin
          r_rcl_count <= 3'd0;
          r_state     <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_alloc_valid = r_alloc_valid;
  assign o_alloc_count = r_alloc_count;
  assign o_alloc_p0    = r_alloc_p0;
  assign o_alloc_p1    = r_alloc_p1;
  assign o_alloc_p2    = r_alloc_p2;
  assign o_alloc_p3    = r_alloc_p3;

`ifdef ALLOC_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_ren_valid && !o_ren_ready && !i_flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_stall_cycles = r_stall_cnt;
`else
  assign o_stall_cycles = '0;
`endif

endmodule
`default_nettype wire
